// File: rtl/pipeline_pkg.sv
// pipeline_pkg
// Shared definitions for the pipeline control slice.
//   cmp_op_e          : encoding of the 3-bit compare operation carried by the s0 instruction
//   N_STAGES_DEFAULT  : default number of stages behind s0 (s1..sN)
package pipeline_pkg;

  typedef enum logic [2:0] {
    CMP_FALSE = 3'd0,
    CMP_EQ    = 3'd1,
    CMP_NE    = 3'd2,
    CMP_LT    = 3'd3,
    CMP_GE    = 3'd4,
    CMP_LTU   = 3'd5,
    CMP_GEU   = 3'd6,
    CMP_TRUE  = 3'd7
  } cmp_op_e;

  localparam int N_STAGES_DEFAULT = 3;

endpackage

// File: rtl/branch_comparator.sv
// branch_comparator
// Purely combinational branch condition evaluator.
//   op    in  3     compare operation (cmp_op_e encoding)
//   a, b  in  XLEN  operands
//   taken out 1     condition result
module branch_comparator
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  // Decode the operation and evaluate the condition; signed and unsigned
  // orderings share the same operands and differ only in interpretation.
  always_comb begin
    taken = 1'b0;
    case (cmp_op_e'(op))
      CMP_FALSE: taken = 1'b0;
      CMP_EQ:    taken = (a == b);
      CMP_NE:    taken = (a != b);
      CMP_LT:    taken = ($signed(a) <  $signed(b));
      CMP_GE:    taken = ($signed(a) >= $signed(b));
      CMP_LTU:   taken = (a <  b);
      CMP_GEU:   taken = (a >= b);
      CMP_TRUE:  taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Fetch/issue control for a short in-order pipeline: fetch (si), s0, then
// N_STAGES stages s1..sN. Handles traps, s1 branches, s0 data-dependency
// replays and memory-port holds.
// Inputs : clk, rst (sync, active high), clk_enable, inst_data_si, mc_s0,
//          cmp_op_s0, jump_s0, data_dep, mem_busy_s1, opnd_a, opnd_b,
//          jmp_addr, trap_valid, trap_addr
// Outputs: pc, pc_s0, ret_addr, inst_data_s0, mc_pipe, id_pipe, valid_pipe,
//          branch_taken, squash
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              PC_W     = 30,
  parameter int              MC_W     = 25,
  parameter int              ID_W     = 25,
  parameter int              N_STAGES = N_STAGES_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable,
  input  logic [ID_W-1:0]          inst_data_si,
  input  logic [MC_W-1:0]          mc_s0,
  input  logic [2:0]               cmp_op_s0,
  input  logic                     jump_s0,
  input  logic                     data_dep,
  input  logic                     mem_busy_s1,
  input  logic [XLEN-1:0]          opnd_a,
  input  logic [XLEN-1:0]          opnd_b,
  input  logic [PC_W-1:0]          jmp_addr,
  input  logic                     trap_valid,
  input  logic [PC_W-1:0]          trap_addr,
  output logic [PC_W-1:0]          pc,
  output logic [PC_W-1:0]          pc_s0,
  output logic [PC_W-1:0]          ret_addr,
  output logic [ID_W-1:0]          inst_data_s0,
  output logic [N_STAGES*MC_W-1:0] mc_pipe,
  output logic [N_STAGES*ID_W-1:0] id_pipe,
  output logic [N_STAGES-1:0]      valid_pipe,
  output logic                     branch_taken,
  output logic                     squash
);

  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PC_W-1:0]     pc_si_q, pc_si_d;
  logic [PC_W-1:0]     pc_s0_q, pc_s0_d;
  logic [PC_W-1:0]     pc_s1_q, pc_s1_d;
  logic                v_si_q, v_si_d;
  logic                v_s0_q, v_s0_d;
  logic [ID_W-1:0]     inst_data_s0_q, inst_data_s0_d;
  logic                taken_s1_q, taken_s1_d;
  logic                jump_s1_q, jump_s1_d;
  logic [MC_W-1:0]     mc_q [N_STAGES];
  logic [MC_W-1:0]     mc_d [N_STAGES];
  logic [ID_W-1:0]     id_q [N_STAGES];
  logic [ID_W-1:0]     id_d [N_STAGES];
  logic [N_STAGES-1:0] valid_q, valid_d;

  logic cmp_taken;
  logic replay;
  logic advance_s0;

  branch_comparator #(.XLEN(XLEN)) u_cmp (
    .op    (cmp_op_s0),
    .a     (opnd_a),
    .b     (opnd_b),
    .taken (cmp_taken)
  );

  // Redirect sources. A replay only matters when s0 really holds an
  // instruction; s0 may move into s1 only when nothing redirects it away.
  assign branch_taken = taken_s1_q & jump_s1_q & valid_q[0];
  assign replay       = data_dep & v_s0_q;
  assign squash       = trap_valid | branch_taken | replay;
  assign advance_s0   = v_s0_q & ~data_dep & ~branch_taken & ~trap_valid;

  // Next-state computation. The fetch pc follows a strict priority
  // (trap, branch, replay, hold, increment). Any redirect invalidates the
  // two younger slots; a memory hold only invalidates the slot being
  // fetched this cycle. s0 never stalls: a blocked s0 instruction is
  // refetched instead, so si and s0 always shift forward.
  always_comb begin
    if (trap_valid) begin
      pc_d = trap_addr;
    end else if (branch_taken) begin
      pc_d = jmp_addr;
    end else if (replay) begin
      pc_d = pc_s0_q;
    end else if (mem_busy_s1) begin
      pc_d = pc_q;
    end else begin
      pc_d = pc_q + PC_W'(1);
    end

    pc_si_d        = pc_q;
    v_si_d         = ~(squash | mem_busy_s1);
    pc_s0_d        = pc_si_q;
    v_s0_d         = v_si_q & ~squash;
    inst_data_s0_d = inst_data_si;

    pc_s1_d    = pc_s1_q;
    mc_d[0]    = '0;
    id_d[0]    = '0;
    valid_d    = '0;
    taken_s1_d = 1'b0;
    jump_s1_d  = 1'b0;
    if (advance_s0) begin
      pc_s1_d    = pc_s0_q;
      mc_d[0]    = mc_s0;
      id_d[0]    = inst_data_s0_q;
      valid_d[0] = 1'b1;
      taken_s1_d = cmp_taken;
      jump_s1_d  = jump_s0;
    end

    for (int k = 1; k < N_STAGES; k++) begin
      mc_d[k]    = mc_q[k-1];
      id_d[k]    = id_q[k-1];
      valid_d[k] = valid_q[k-1];
    end
  end

  // State registers. Reset wins over the enable so a frozen pipeline can
  // still be reset; otherwise everything moves only on enabled edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      pc_si_q        <= '0;
      pc_s0_q        <= '0;
      pc_s1_q        <= '0;
      v_si_q         <= 1'b0;
      v_s0_q         <= 1'b0;
      inst_data_s0_q <= '0;
      taken_s1_q     <= 1'b0;
      jump_s1_q      <= 1'b0;
      valid_q        <= '0;
      for (int k = 0; k < N_STAGES; k++) begin
        mc_q[k] <= '0;
        id_q[k] <= '0;
      end
    end else if (clk_enable) begin
      pc_q           <= pc_d;
      pc_si_q        <= pc_si_d;
      pc_s0_q        <= pc_s0_d;
      pc_s1_q        <= pc_s1_d;
      v_si_q         <= v_si_d;
      v_s0_q         <= v_s0_d;
      inst_data_s0_q <= inst_data_s0_d;
      taken_s1_q     <= taken_s1_d;
      jump_s1_q      <= jump_s1_d;
      valid_q        <= valid_d;
      for (int k = 0; k < N_STAGES; k++) begin
        mc_q[k] <= mc_d[k];
        id_q[k] <= id_d[k];
      end
    end
  end

  // Flatten the per-stage arrays onto the packed output buses, slot k = s(k+1).
  for (genvar k = 0; k < N_STAGES; k++) begin : g_pack
    assign mc_pipe[k*MC_W +: MC_W] = mc_q[k];
    assign id_pipe[k*ID_W +: ID_W] = id_q[k];
  end

  assign valid_pipe   = valid_q;
  assign pc           = pc_q;
  assign pc_s0        = pc_s0_q;
  assign ret_addr     = pc_s1_q;
  assign inst_data_s0 = inst_data_s0_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// randomized traffic, all compared every cycle against an instruction-level
// reference model (fetch slot, s0 slot and a queue of s1..sN instructions).
module tb_pipeline_ctrl;

  localparam int              XLEN     = 32;
  localparam int              PC_W     = 30;
  localparam int              MC_W     = 25;
  localparam int              ID_W     = 25;
  localparam int              N_STAGES = 3;
  localparam logic [PC_W-1:0] RESET_PC = 30'h10;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     clk_enable;
  logic [ID_W-1:0]          inst_data_si;
  logic [MC_W-1:0]          mc_s0;
  logic [2:0]               cmp_op_s0;
  logic                     jump_s0;
  logic                     data_dep;
  logic                     mem_busy_s1;
  logic [XLEN-1:0]          opnd_a;
  logic [XLEN-1:0]          opnd_b;
  logic [PC_W-1:0]          jmp_addr;
  logic                     trap_valid;
  logic [PC_W-1:0]          trap_addr;
  logic [PC_W-1:0]          pc;
  logic [PC_W-1:0]          pc_s0;
  logic [PC_W-1:0]          ret_addr;
  logic [ID_W-1:0]          inst_data_s0;
  logic [N_STAGES*MC_W-1:0] mc_pipe;
  logic [N_STAGES*ID_W-1:0] id_pipe;
  logic [N_STAGES-1:0]      valid_pipe;
  logic                     branch_taken;
  logic                     squash;

  int vectors    = 0;
  int miscompares = 0;

  pipeline_ctrl #(
    .XLEN(XLEN), .PC_W(PC_W), .MC_W(MC_W), .ID_W(ID_W),
    .N_STAGES(N_STAGES), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .clk_enable(clk_enable),
    .inst_data_si(inst_data_si), .mc_s0(mc_s0), .cmp_op_s0(cmp_op_s0),
    .jump_s0(jump_s0), .data_dep(data_dep), .mem_busy_s1(mem_busy_s1),
    .opnd_a(opnd_a), .opnd_b(opnd_b), .jmp_addr(jmp_addr),
    .trap_valid(trap_valid), .trap_addr(trap_addr),
    .pc(pc), .pc_s0(pc_s0), .ret_addr(ret_addr), .inst_data_s0(inst_data_s0),
    .mc_pipe(mc_pipe), .id_pipe(id_pipe), .valid_pipe(valid_pipe),
    .branch_taken(branch_taken), .squash(squash)
  );

  always #5 clk = ~clk;

  // Reference model: one record per instruction slot.
  typedef struct {
    logic [PC_W-1:0] pc;
    logic            v;
    logic [ID_W-1:0] data;
    logic [MC_W-1:0] mc;
    logic            jump;
    logic            taken;
  } slot_t;

  slot_t           m_fetch;
  slot_t           m_s0;
  slot_t           m_pipe[$];
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_ret;
  logic            model_known = 1'b0;

  function automatic slot_t emptySlot();
    slot_t s;
    s.pc = '0; s.v = 1'b0; s.data = '0; s.mc = '0; s.jump = 1'b0; s.taken = 1'b0;
    return s;
  endfunction

  // Condition evaluated on widened integers rather than bit tricks.
  function automatic logic refCompare(input logic [2:0] op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (op)
      3'd1:    return ua == ub;
      3'd2:    return ua != ub;
      3'd3:    return sa < sb;
      3'd4:    return sa >= sb;
      3'd5:    return ua < ub;
      3'd6:    return ua >= ub;
      3'd7:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic modelBranch();
    return m_pipe[0].v && m_pipe[0].jump && m_pipe[0].taken;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  task automatic modelStep();
    logic            bt, rep, redirect, adv;
    logic [PC_W-1:0] npc;
    slot_t           ins;
    if (rst) begin
      m_pc = RESET_PC;
      m_ret = '0;
      m_fetch = emptySlot();
      m_s0 = emptySlot();
      m_pipe.delete();
      for (int k = 0; k < N_STAGES; k++) m_pipe.push_back(emptySlot());
      model_known = 1'b1;
      return;
    end
    if (!clk_enable || !model_known) return;
    bt       = modelBranch();
    rep      = data_dep && m_s0.v;
    redirect = trap_valid || bt || rep;
    adv      = m_s0.v && !data_dep && !bt && !trap_valid;
    ins = emptySlot();
    if (adv) begin
      ins.pc = m_s0.pc; ins.v = 1'b1; ins.data = m_s0.data; ins.mc = mc_s0;
      ins.jump = jump_s0; ins.taken = refCompare(cmp_op_s0, opnd_a, opnd_b);
      m_ret = m_s0.pc;
    end
    m_pipe.push_front(ins);
    void'(m_pipe.pop_back());
    if (trap_valid)       npc = trap_addr;
    else if (bt)          npc = jmp_addr;
    else if (rep)         npc = m_s0.pc;
    else if (mem_busy_s1) npc = m_pc;
    else                  npc = PC_W'((longint'(m_pc) + 1) % (longint'(1) << PC_W));
    m_s0.pc = m_fetch.pc;
    m_s0.v = m_fetch.v && !redirect;
    m_s0.data = inst_data_si;
    m_fetch.pc = m_pc;
    m_fetch.v = !(redirect || mem_busy_s1);
    m_pc = npc;
  endtask

  task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model's view of the current cycle.
  task automatic checkOutput();
    logic [N_STAGES*MC_W-1:0] exp_mc;
    logic [N_STAGES*ID_W-1:0] exp_id;
    logic [N_STAGES-1:0]      exp_v;
    logic                     exp_bt;
    if (!model_known) return;
    for (int k = 0; k < N_STAGES; k++) begin
      exp_mc[k*MC_W +: MC_W] = m_pipe[k].mc;
      exp_id[k*ID_W +: ID_W] = m_pipe[k].data;
      exp_v[k]               = m_pipe[k].v;
    end
    exp_bt = modelBranch();
    checkVal("pc", 128'(pc), 128'(m_pc));
    checkVal("pc_s0", 128'(pc_s0), 128'(m_s0.pc));
    checkVal("ret_addr", 128'(ret_addr), 128'(m_ret));
    checkVal("inst_data_s0", 128'(inst_data_s0), 128'(m_s0.data));
    checkVal("mc_pipe", 128'(mc_pipe), 128'(exp_mc));
    checkVal("id_pipe", 128'(id_pipe), 128'(exp_id));
    checkVal("valid_pipe", 128'(valid_pipe), 128'(exp_v));
    checkVal("branch_taken", 128'(branch_taken), 128'(exp_bt));
    checkVal("squash", 128'(squash), 128'(trap_valid || exp_bt || (data_dep && m_s0.v)));
  endtask

  // Inputs are already set; wait for the sampling point and compare.
  task automatic applyStimulus();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic setIdle();
    rst = 1'b0; clk_enable = 1'b1;
    data_dep = 1'b0; mem_busy_s1 = 1'b0; trap_valid = 1'b0;
    jump_s0 = 1'b0; cmp_op_s0 = 3'd0;
    trap_addr = PC_W'($urandom); jmp_addr = PC_W'($urandom);
    opnd_a = $urandom; opnd_b = $urandom;
    inst_data_si = ID_W'($urandom); mc_s0 = MC_W'($urandom);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      setIdle(); applyStimulus(); tick();
    end
  endtask

  task automatic randomStim();
    rst          = ($urandom_range(63) == 0);
    clk_enable   = ($urandom_range(7) != 0);
    trap_valid   = ($urandom_range(15) == 0);
    data_dep     = ($urandom_range(5) == 0);
    mem_busy_s1  = ($urandom_range(5) == 0);
    jump_s0      = 1'($urandom_range(1));
    cmp_op_s0    = 3'($urandom_range(7));
    opnd_a       = $urandom;
    opnd_b       = ($urandom_range(3) == 0) ? opnd_a : $urandom;
    jmp_addr     = PC_W'($urandom);
    trap_addr    = PC_W'($urandom);
    inst_data_si = ID_W'($urandom);
    mc_s0        = MC_W'($urandom);
  endtask

  initial begin
    // Reset, then straight-line fetch from RESET_PC.
    setIdle(); rst = 1'b1;
    applyStimulus(); tick();
    for (int c = 0; c < 4; c++) begin
      setIdle(); applyStimulus();
      checkVal("seq_pc", 128'(pc), 128'(32'h10 + c));
      checkVal("seq_s1_valid", 128'(valid_pipe[0]), 128'(c == 3));
      if (c == 2) checkVal("seq_pc_s0", 128'(pc_s0), 128'(30'h10));
      tick();
    end

    // Signed less-than branch from s1 to 0x40.
    setIdle(); cmp_op_s0 = 3'd3; opnd_a = 32'hFFFF_FFFF; opnd_b = 32'h1; jump_s0 = 1'b1;
    applyStimulus(); checkVal("br_pc_s0", 128'(pc_s0), 128'(30'h12)); tick();
    setIdle(); jmp_addr = 30'h40; applyStimulus();
    checkVal("br_taken", 128'(branch_taken), 128'(1'b1));
    checkVal("br_ret_addr", 128'(ret_addr), 128'(30'h12));
    tick();
    setIdle(); applyStimulus();
    checkVal("br_pc", 128'(pc), 128'(30'h40));
    checkVal("br_bubble1", 128'(valid_pipe[0]), 128'(1'b0));
    tick();
    setIdle(); applyStimulus(); checkVal("br_bubble2", 128'(valid_pipe[0]), 128'(1'b0)); tick();
    setIdle(); applyStimulus(); checkVal("br_target_s0", 128'(pc_s0), 128'(30'h40)); tick();

    // Same operands, unsigned less-than: no branch.
    setIdle(); cmp_op_s0 = 3'd5; opnd_a = 32'hFFFF_FFFF; opnd_b = 32'h1; jump_s0 = 1'b1;
    jmp_addr = 30'h99;
    applyStimulus(); checkVal("nbr_pc_s0", 128'(pc_s0), 128'(30'h41)); tick();
    setIdle(); applyStimulus();
    checkVal("nbr_taken", 128'(branch_taken), 128'(1'b0));
    checkVal("nbr_ret_addr", 128'(ret_addr), 128'(30'h41));
    checkVal("nbr_pc", 128'(pc), 128'(30'h44));
    tick();
    setIdle(); applyStimulus(); checkVal("nbr_pc_next", 128'(pc), 128'(30'h45)); tick();

    // Replay of the instruction at 0x22.
    setIdle(); trap_valid = 1'b1; trap_addr = 30'h20; applyStimulus(); tick();
    idleCycles(4);
    setIdle(); data_dep = 1'b1; applyStimulus();
    checkVal("rep_pc_s0", 128'(pc_s0), 128'(30'h22));
    checkVal("rep_squash", 128'(squash), 128'(1'b1));
    tick();
    setIdle(); applyStimulus();
    checkVal("rep_pc", 128'(pc), 128'(30'h22));
    checkVal("rep_bubble", 128'(valid_pipe[0]), 128'(1'b0));
    tick();
    idleCycles(1);
    setIdle(); applyStimulus(); checkVal("rep_back_s0", 128'(pc_s0), 128'(30'h22)); tick();

    // Trap, branch and replay together: trap wins, one squash cycle.
    setIdle(); cmp_op_s0 = 3'd7; jump_s0 = 1'b1; applyStimulus();
    checkVal("pri_pc_s0", 128'(pc_s0), 128'(30'h23));
    tick();
    setIdle(); trap_valid = 1'b1; trap_addr = 30'h80; data_dep = 1'b1; jmp_addr = 30'h60;
    applyStimulus();
    checkVal("pri_branch", 128'(branch_taken), 128'(1'b1));
    checkVal("pri_squash", 128'(squash), 128'(1'b1));
    tick();
    setIdle(); applyStimulus();
    checkVal("pri_pc", 128'(pc), 128'(30'h80));
    checkVal("pri_single_squash", 128'(squash), 128'(1'b0));
    tick();

    // pc wrap at the top of the address space.
    setIdle(); trap_valid = 1'b1; trap_addr = 30'h3FFF_FFFF; applyStimulus(); tick();
    setIdle(); applyStimulus(); checkVal("wrap_top", 128'(pc), 128'(30'h3FFF_FFFF)); tick();
    setIdle(); applyStimulus(); checkVal("wrap_zero", 128'(pc), 128'(30'h0)); tick();

    // Enable low for 5 cycles while events are requested.
    for (int i = 0; i < 5; i++) begin
      setIdle(); clk_enable = 1'b0; trap_valid = 1'(i % 2); trap_addr = 30'h55; data_dep = 1'b1;
      applyStimulus();
      checkVal("frz_pc", 128'(pc), 128'(30'h1));
      checkVal("frz_pc_s0", 128'(pc_s0), 128'(30'h3FFF_FFFF));
      tick();
    end
    setIdle(); applyStimulus(); checkVal("frz_resume", 128'(pc), 128'(30'h1)); tick();
    setIdle(); applyStimulus(); checkVal("frz_resume_inc", 128'(pc), 128'(30'h2)); tick();

    // Reset while disabled and mid-trap.
    setIdle(); clk_enable = 1'b0; rst = 1'b1; trap_valid = 1'b1; trap_addr = 30'h77;
    applyStimulus(); tick();
    setIdle(); applyStimulus();
    checkVal("rst_pc", 128'(pc), 128'(RESET_PC));
    checkVal("rst_valid", 128'(valid_pipe), 128'(3'b000));
    checkVal("rst_mc", 128'(mc_pipe), 128'(0));
    checkVal("rst_pc_s0", 128'(pc_s0), 128'(0));
    checkVal("rst_data_s0", 128'(inst_data_s0), 128'(0));
    tick();
    setIdle(); applyStimulus(); checkVal("rst_pc_next", 128'(pc), 128'(30'h11)); tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      randomStim(); applyStimulus(); tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
